// File: rtl/issue_scheduler.sv
// issue_scheduler: in-order issue queue between fetch and decode.
// Buffers fetched instructions in a DEPTH-entry circular FIFO, presents the
// head instruction/PC to the decoder, pops on decoder room, sequences a
// one-cycle flush recovery and counts structural stall cycles.
//
// Ports:
//   clk_in, rst_in      clock, asynchronous active-low reset
//   rdy_in              global ready; low freezes queue and stall counter
//   flush_in            misprediction clear (highest priority)
//   fetch_valid/inst/pc fetch offer; fetch_ready accepts it
//   station_idle_in     decoder has ROB/RS/LSB room for the head
//   inst_to_dec/pc_to_dec/if_ls_to_dec  head presentation (0 when empty)
//   issue_fire          head issued and popped this cycle
//   stall_cnt           saturating structural-stall cycle counter
module issue_scheduler #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned INST_W = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              fetch_valid,
    input  logic [INST_W-1:0] fetch_inst,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic              fetch_ready,
    input  logic              station_idle_in,
    output logic [INST_W-1:0] inst_to_dec,
    output logic [ADDR_W-1:0] pc_to_dec,
    output logic              if_ls_to_dec,
    output logic              issue_fire,
    output logic [15:0]       stall_cnt
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic {
        S_FLUSH = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];

    logic presenting;
    logic push;
    logic pop;
    logic stall_inc;

    // Next state: any flush lands in S_FLUSH, otherwise run.
    always_comb begin
        state_nxt = S_RUN;
        if (flush_in) begin
            state_nxt = S_FLUSH;
        end
    end

    // Handshakes and head presentation.
    always_comb begin
        presenting   = 1'b0;
        fetch_ready  = 1'b0;
        issue_fire   = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        stall_inc    = 1'b0;
        inst_to_dec  = '0;
        pc_to_dec    = '0;
        if_ls_to_dec = 1'b0;

        presenting  = (state == S_RUN) && (count != '0);
        // No full-queue bypass: a full queue refuses even when popping.
        fetch_ready = (state == S_RUN) && (count != CNT_FULL) && rdy_in;
        issue_fire  = presenting && station_idle_in && rdy_in && !flush_in;
        push        = fetch_valid && fetch_ready && !flush_in;
        pop         = issue_fire;
        stall_inc   = presenting && rdy_in && !station_idle_in && !flush_in;

        if (presenting) begin
            inst_to_dec  = inst_mem[head];
            pc_to_dec    = pc_mem[head];
            if_ls_to_dec = (inst_mem[head][6:0] == OP_LOAD) ||
                           (inst_mem[head][6:0] == OP_STORE);
        end
    end

    // State register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= S_FLUSH;
        end else begin
            state <= state_nxt;
        end
    end

    // Queue pointers and occupancy; flush clears everything.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; payload needs no reset since count gates visibility.
    always_ff @(posedge clk_in) begin
        if (push) begin
            inst_mem[tail] <= fetch_inst;
            pc_mem[tail]   <= fetch_pc;
        end
    end

    // Saturating stall counter; survives flush, cleared only by reset.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            stall_cnt <= '0;
        end else if (stall_inc && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed self-checking bench for issue_scheduler.
module tb_issue_scheduler;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush_in;
    logic        fetch_valid;
    logic [31:0] fetch_inst;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    logic        station_idle_in;
    logic [31:0] inst_to_dec;
    logic [31:0] pc_to_dec;
    logic        if_ls_to_dec;
    logic        issue_fire;
    logic [15:0] stall_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    issue_scheduler #(.DEPTH(4), .INST_W(32), .ADDR_W(32)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .flush_in        (flush_in),
        .fetch_valid     (fetch_valid),
        .fetch_inst      (fetch_inst),
        .fetch_pc        (fetch_pc),
        .fetch_ready     (fetch_ready),
        .station_idle_in (station_idle_in),
        .inst_to_dec     (inst_to_dec),
        .pc_to_dec       (pc_to_dec),
        .if_ls_to_dec    (if_ls_to_dec),
        .issue_fire      (issue_fire),
        .stall_cnt       (stall_cnt)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past a rising edge and park on the falling edge.
    task automatic tick();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    function automatic logic [31:0] alu_inst(input int i);
        return 32'h0000_0013 + (32'(i) << 8);
    endfunction

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
        fetch_valid = 1'b1; fetch_inst = 32'h00500093; fetch_pc = 32'h0;
        station_idle_in = 1'b1;
        #12;
        check("rst_fetch_ready", 64'(fetch_ready), 64'd0);
        check("rst_issue_fire", 64'(issue_fire), 64'd0);
        check("rst_inst", 64'(inst_to_dec), 64'd0);
        check("rst_pc", 64'(pc_to_dec), 64'd0);
        check("rst_ls", 64'(if_ls_to_dec), 64'd0);
        check("rst_stall", 64'(stall_cnt), 64'd0);

        // Reset then stream two instructions.
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        check("c1_fetch_ready", 64'(fetch_ready), 64'd0);
        tick();
        #1;
        check("c2_fetch_ready", 64'(fetch_ready), 64'd1);
        check("c2_inst_empty", 64'(inst_to_dec), 64'd0);
        check("c2_issue", 64'(issue_fire), 64'd0);
        tick();
        fetch_inst = 32'h00002103; fetch_pc = 32'h4;
        #1;
        check("c3_issue", 64'(issue_fire), 64'd1);
        check("c3_inst", 64'(inst_to_dec), 64'h00500093);
        check("c3_pc", 64'(pc_to_dec), 64'h0);
        check("c3_ls", 64'(if_ls_to_dec), 64'd0);
        tick();
        fetch_valid = 1'b0;
        #1;
        check("c4_issue", 64'(issue_fire), 64'd1);
        check("c4_inst", 64'(inst_to_dec), 64'h00002103);
        check("c4_pc", 64'(pc_to_dec), 64'h4);
        check("c4_ls", 64'(if_ls_to_dec), 64'd1);
        tick();
        #1;
        check("c5_issue", 64'(issue_fire), 64'd0);
        check("c5_inst_empty", 64'(inst_to_dec), 64'd0);
        check("c5_pc_empty", 64'(pc_to_dec), 64'd0);
        check("c5_stall", 64'(stall_cnt), 64'd0);

        // Fill to full with the decoder blocked; pointers start at 2.
        station_idle_in = 1'b0;
        fetch_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            fetch_inst = alu_inst(i); fetch_pc = 32'h100 + 32'(4 * i);
            #1;
            check($sformatf("fill_ready_%0d", i), 64'(fetch_ready), (i < 4) ? 64'd1 : 64'd0);
            check($sformatf("fill_stall_%0d", i), 64'(stall_cnt), (i == 0) ? 64'd0 : 64'(i - 1));
            check($sformatf("fill_noissue_%0d", i), 64'(issue_fire), 64'd0);
            tick();
        end
        fetch_valid = 1'b0;
        #1;
        check("full_stall", 64'(stall_cnt), 64'd4);
        station_idle_in = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1;
            check($sformatf("drain_issue_%0d", j), 64'(issue_fire), 64'd1);
            check($sformatf("drain_inst_%0d", j), 64'(inst_to_dec), 64'(alu_inst(j)));
            check($sformatf("drain_pc_%0d", j), 64'(pc_to_dec), 64'(32'h100 + 32'(4 * j)));
            tick();
        end
        #1;
        check("drain_empty_issue", 64'(issue_fire), 64'd0);
        check("drain_empty_inst", 64'(inst_to_dec), 64'd0);
        check("drain_stall", 64'(stall_cnt), 64'd4);

        // Steady push/pop at occupancy 2.
        station_idle_in = 1'b0;
        fetch_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            fetch_inst = alu_inst(16 + k); fetch_pc = 32'h200 + 32'(4 * k);
            tick();
        end
        #1;
        check("pp_pre_stall", 64'(stall_cnt), 64'd5);
        station_idle_in = 1'b1;
        for (int k = 0; k < 10; k++) begin
            fetch_inst = alu_inst(18 + k); fetch_pc = 32'h200 + 32'(4 * (k + 2));
            #1;
            check($sformatf("pp_issue_%0d", k), 64'(issue_fire), 64'd1);
            check($sformatf("pp_ready_%0d", k), 64'(fetch_ready), 64'd1);
            check($sformatf("pp_inst_%0d", k), 64'(inst_to_dec), 64'(alu_inst(16 + k)));
            tick();
        end
        fetch_valid = 1'b0;
        for (int k = 10; k < 12; k++) begin
            #1;
            check($sformatf("pp_tail_inst_%0d", k), 64'(inst_to_dec), 64'(alu_inst(16 + k)));
            check($sformatf("pp_tail_issue_%0d", k), 64'(issue_fire), 64'd1);
            tick();
        end
        #1;
        check("pp_empty", 64'(inst_to_dec), 64'd0);
        check("pp_stall", 64'(stall_cnt), 64'd5);

        // Flush with 3 queued while a push and an issue would coincide.
        station_idle_in = 1'b0;
        fetch_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            fetch_inst = alu_inst(40 + k); fetch_pc = 32'h300 + 32'(4 * k);
            tick();
        end
        station_idle_in = 1'b1;
        flush_in = 1'b1;
        fetch_inst = alu_inst(50);
        #1;
        check("fl_issue_forced", 64'(issue_fire), 64'd0);
        check("fl_head_still", 64'(inst_to_dec), 64'(alu_inst(40)));
        tick();
        flush_in = 1'b0;
        #1;
        check("fl_state_ready", 64'(fetch_ready), 64'd0);
        check("fl_state_inst", 64'(inst_to_dec), 64'd0);
        check("fl_state_issue", 64'(issue_fire), 64'd0);
        tick();
        fetch_valid = 1'b0;
        #1;
        check("fl_after_ready", 64'(fetch_ready), 64'd1);
        check("fl_after_empty", 64'(inst_to_dec), 64'd0);
        check("fl_after_issue", 64'(issue_fire), 64'd0);
        check("fl_stall", 64'(stall_cnt), 64'd7);

        // rdy_in low freezes issue, accept and stall counting.
        fetch_valid = 1'b1; fetch_inst = 32'h00A12023; fetch_pc = 32'h400;
        tick();
        rdy_in = 1'b0;
        fetch_inst = alu_inst(60); fetch_pc = 32'h404;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("rdy_issue_%0d", k), 64'(issue_fire), 64'd0);
            check($sformatf("rdy_ready_%0d", k), 64'(fetch_ready), 64'd0);
            check($sformatf("rdy_inst_%0d", k), 64'(inst_to_dec), 64'h00A12023);
            check($sformatf("rdy_ls_%0d", k), 64'(if_ls_to_dec), 64'd1);
            tick();
        end
        rdy_in = 1'b1; fetch_valid = 1'b0;
        #1;
        check("rdy_release_issue", 64'(issue_fire), 64'd1);
        check("rdy_stall", 64'(stall_cnt), 64'd7);
        tick();
        #1;
        check("rdy_empty", 64'(inst_to_dec), 64'd0);

        // Saturation of the stall counter and survival across flush.
        station_idle_in = 1'b0;
        fetch_valid = 1'b1; fetch_inst = alu_inst(70); fetch_pc = 32'h500;
        tick();
        fetch_valid = 1'b0;
        repeat (1000) tick();
        #1;
        check("sat_mid", 64'(stall_cnt), 64'd1007);
        repeat (69000) tick();
        #1;
        check("sat_hold", 64'(stall_cnt), 64'hFFFF);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        tick();
        #1;
        check("sat_after_flush", 64'(stall_cnt), 64'hFFFF);
        check("sat_after_flush_ready", 64'(fetch_ready), 64'd1);
        check("sat_after_flush_empty", 64'(inst_to_dec), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
